// File: rtl/f1_seq_pkg.sv
// Shared types, widths and helpers for the F1 start-light reaction timer.
package f1_seq_pkg;

    localparam int LIGHT_W = 10;   // width of the light pattern
    localparam int CNT_W   = 4;    // light counter, counts 0..10
    localparam int DELAY_W = 12;   // random hold counter in ms
    localparam int REACT_W = 14;   // reaction time in ms
    localparam int RND_W   = 6;    // external random value

    localparam int MAX_REACT_MS_DEFAULT = 9999;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LIGHTS,
        ST_RAND_WAIT,
        ST_TIMING,
        ST_DONE,
        ST_JUMP
    } state_t;

    // Random hold length: a zero draw is treated as one unit so lights never go
    // out on the same tick they complete.
    function automatic logic [DELAY_W-1:0] hold_ms(input logic [RND_W-1:0] rnd,
                                                   input logic [31:0]      unit_ms);
        logic [RND_W-1:0] units;
        logic [31:0]      prod;
        units = (rnd == '0) ? RND_W'(1) : rnd;
        prod  = 32'(units) * unit_ms;
        return prod[DELAY_W-1:0];
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level input already synchronous to clk.
// The detector stays disarmed for the first cycle after reset so that a button
// held through reset release is seen as "already pressed" rather than as a new edge.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic prev_q, prev_d;
    logic armed_q, armed_d;

    // Next-state: track the input and arm after the first clock out of reset.
    always_comb begin
        prev_d  = din;
        armed_d = 1'b1;
    end

    // Registered copy of the input plus the arm flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign rise = armed_q & din & ~prev_q;

endmodule

// File: rtl/f1_race_sequencer.sv
// F1 start-light sequencer and reaction timer.
// trigger starts a light-up sequence (one light per half second), then after a
// random hold all lights go out and reaction time is counted in ms until react.
// Reacting before lights-out is a jump start.
module f1_race_sequencer
    import f1_seq_pkg::*;
#(
    parameter int NUM_LIGHTS    = 10,
    parameter int DELAY_UNIT_MS = 50,
    parameter int MAX_REACT_MS  = MAX_REACT_MS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_ms,
    input  logic               tick_halfs,
    input  logic               trigger,
    input  logic               react,
    input  logic [RND_W-1:0]   rnd,
    output logic               en_lfsr,
    output logic [LIGHT_W-1:0] ledr,
    output logic [REACT_W-1:0] react_ms,
    output logic               result_valid,
    output logic               jump_start,
    output logic               busy
);

    localparam logic [CNT_W-1:0]   LAST_LIGHT = CNT_W'(NUM_LIGHTS);
    localparam logic [REACT_W-1:0] MAX_REACT  = REACT_W'(MAX_REACT_MS);

    logic trig_rise;
    logic react_rise;

    state_t               state_q, state_d;
    logic [LIGHT_W-1:0]   ledr_q, ledr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [REACT_W-1:0]   react_ms_q, react_ms_d;
    logic                 result_valid_q, result_valid_d;
    logic                 jump_start_q, jump_start_d;

    logic [CNT_W-1:0]     cnt_inc;
    logic [REACT_W-1:0]   react_inc;

    rise_detect u_trig_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (trigger),
        .rise  (trig_rise)
    );

    rise_detect u_react_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (react),
        .rise  (react_rise)
    );

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign react_inc = react_ms_q + REACT_W'(1);

    // Next-state and datapath: react edges take priority over ticks in every
    // active state, trigger edges take priority over react in the rest states.
    always_comb begin
        state_d        = state_q;
        ledr_d         = ledr_q;
        cnt_d          = cnt_q;
        delay_d        = delay_q;
        react_ms_d     = react_ms_q;
        result_valid_d = 1'b0;
        jump_start_d   = jump_start_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_JUMP: begin
                if (trig_rise) begin
                    state_d      = ST_LIGHTS;
                    ledr_d       = '0;
                    cnt_d        = '0;
                    react_ms_d   = '0;
                    jump_start_d = 1'b0;
                end
            end

            ST_LIGHTS: begin
                if (react_rise) begin
                    state_d      = ST_JUMP;
                    jump_start_d = 1'b1;
                    ledr_d       = '1;
                    react_ms_d   = '0;
                end else if (tick_halfs) begin
                    ledr_d = {ledr_q[LIGHT_W-2:0], 1'b1};
                    cnt_d  = cnt_inc;
                    if (cnt_inc == LAST_LIGHT) begin
                        delay_d = hold_ms(rnd, 32'(DELAY_UNIT_MS));
                        state_d = ST_RAND_WAIT;
                    end
                end
            end

            ST_RAND_WAIT: begin
                if (react_rise) begin
                    state_d      = ST_JUMP;
                    jump_start_d = 1'b1;
                    ledr_d       = '1;
                    react_ms_d   = '0;
                end else if (tick_ms) begin
                    if (delay_q <= DELAY_W'(1)) begin
                        state_d    = ST_TIMING;
                        delay_d    = '0;
                        ledr_d     = '0;
                        react_ms_d = '0;
                    end else begin
                        delay_d = delay_q - DELAY_W'(1);
                    end
                end
            end

            ST_TIMING: begin
                if (react_rise) begin
                    state_d        = ST_DONE;
                    result_valid_d = 1'b1;
                end else if (tick_ms) begin
                    if (react_inc >= MAX_REACT) begin
                        react_ms_d     = MAX_REACT;
                        state_d        = ST_DONE;
                        result_valid_d = 1'b1;
                    end else begin
                        react_ms_d = react_inc;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                ledr_d  = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ledr_q         <= '0;
            cnt_q          <= '0;
            delay_q        <= '0;
            react_ms_q     <= '0;
            result_valid_q <= 1'b0;
            jump_start_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            ledr_q         <= ledr_d;
            cnt_q          <= cnt_d;
            delay_q        <= delay_d;
            react_ms_q     <= react_ms_d;
            result_valid_q <= result_valid_d;
            jump_start_q   <= jump_start_d;
        end
    end

    assign en_lfsr      = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_LIGHTS) || (state_q == ST_RAND_WAIT) ||
                          (state_q == ST_TIMING);
    assign ledr         = ledr_q;
    assign react_ms     = react_ms_q;
    assign result_valid = result_valid_q;
    assign jump_start   = jump_start_q;

endmodule

// File: tb/tb_f1_race_sequencer.sv
// Bench for f1_race_sequencer. One simulated millisecond is two clocks: a tick
// cycle followed by a quiet cycle. Button presses normally land on a quiet
// cycle; do_ms(1) lands a react press on the tick cycle itself.
// Result strobes and jump-start entries are checked by a monitor against an
// expected queue filled by the stimulus.
module tb_f1_race_sequencer;

    logic        clk;
    logic        rst_n;
    logic        tick_ms;
    logic        tick_halfs;
    logic        trigger;
    logic        react;
    logic [5:0]  rnd;
    logic        en_lfsr;
    logic [9:0]  ledr;
    logic [13:0] react_ms;
    logic        result_valid;
    logic        jump_start;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int ms_idx = 0;

    // Expected events: bit 15 = 1 -> jump entry with ledr in [9:0];
    //                  bit 15 = 0 -> result strobe with react_ms in [13:0].
    logic [15:0] exp_q[$];
    logic        js_prev;

    f1_race_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_ms      (tick_ms),
        .tick_halfs   (tick_halfs),
        .trigger      (trigger),
        .react        (react),
        .rnd          (rnd),
        .en_lfsr      (en_lfsr),
        .ledr         (ledr),
        .react_ms     (react_ms),
        .result_valid (result_valid),
        .jump_start   (jump_start),
        .busy         (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must end on its own
    initial begin
        #1_200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    // One millisecond; tick_halfs every 500th tick_ms.
    task automatic do_ms(input logic react_now);
        @(negedge clk);
        tick_ms    = 1'b1;
        tick_halfs = (ms_idx % 500 == 499);
        ms_idx++;
        if (react_now) react = 1'b1;
        @(negedge clk);
        tick_ms    = 1'b0;
        tick_halfs = 1'b0;
    endtask

    task automatic run_ms(input int n);
        for (int i = 0; i < n; i++) do_ms(1'b0);
    endtask

    task automatic press_trigger();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_react();
        react = 1'b1;
        @(negedge clk);
        react = 1'b0;
        @(negedge clk);
    endtask

    // Advance until ledr changes or max_ms elapse.
    task automatic wait_change(input int max_ms, output int elapsed);
        logic [9:0] prev;
        prev    = ledr;
        elapsed = 0;
        while (ledr == prev && elapsed < max_ms) begin
            do_ms(1'b0);
            elapsed++;
        end
    endtask

    // Wait for lights 1..n, checking the pattern and the 500 ms spacing.
    task automatic lights_up(input int n, input string tag);
        int el;
        logic [9:0] pat;
        for (int k = 1; k <= n; k++) begin
            wait_change(600, el);
            pat = 10'((1 << k) - 1);
            check({tag, "_light_pattern"}, 32'(ledr), 32'(pat));
            if (k > 1) check({tag, "_light_spacing_ms"}, 32'(el), 32'd500);
        end
    endtask

    // Scoreboard monitor: compare every result strobe and jump entry
    always @(negedge clk) begin
        if (!rst_n) begin
            js_prev <= 1'b0;
        end else begin
            js_prev <= jump_start;
            if (result_valid || (jump_start && !js_prev)) begin
                logic [15:0] got;
                got = result_valid ? {2'b00, react_ms} : {1'b1, 5'd0, ledr};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_event: got 0x%0h expected no event", got);
                end else begin
                    logic [15:0] exp;
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL sb_event: got 0x%0h expected 0x%0h", got, exp);
                    end
                end
            end
        end
    end

    initial begin
        int el;
        rst_n      = 1'b0;
        tick_ms    = 1'b0;
        tick_halfs = 1'b0;
        trigger    = 1'b0;
        react      = 1'b0;
        rnd        = 6'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ledr", 32'(ledr), 32'd0);
        check("rst_react_ms", 32'(react_ms), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_jump_start", 32'(jump_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en_lfsr", 32'(en_lfsr), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal run: rnd=20 -> 1000 ms hold, react 180 ms after lights-out
        rnd = 6'd20;
        run_ms(3);
        check("t1_idle_en_lfsr", 32'(en_lfsr), 32'd1);
        press_trigger();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_en_lfsr_off", 32'(en_lfsr), 32'd0);
        check("t1_ledr_start", 32'(ledr), 32'd0);
        lights_up(10, "t1");
        wait_change(1100, el);
        check("t1_hold_ms", 32'(el), 32'd1000);
        check("t1_lights_out", 32'(ledr), 32'd0);
        check("t1_react_ms_zero", 32'(react_ms), 32'd0);
        run_ms(180);
        check("t1_react_ms_count", 32'(react_ms), 32'd180);
        exp_q.push_back({2'b00, 14'd180});
        press_react();
        check("t1_done_react_ms", 32'(react_ms), 32'd180);
        check("t1_done_busy", 32'(busy), 32'd0);
        check("t1_done_jump", 32'(jump_start), 32'd0);
        run_ms(20);
        check("t1_done_hold", 32'(react_ms), 32'd180);

        // Trigger and react together in DONE: trigger wins. Then rnd=0 -> 50 ms
        // hold, react edge coincident with tick_ms at 250 ms.
        rnd     = 6'd0;
        trigger = 1'b1;
        react   = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        @(negedge clk);
        react = 1'b0;
        @(negedge clk);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_no_jump", 32'(jump_start), 32'd0);
        check("t2_react_ms_clear", 32'(react_ms), 32'd0);
        check("t2_ledr_clear", 32'(ledr), 32'd0);
        lights_up(1, "t2a");
        press_trigger();
        check("t2_trigger_ignored", 32'(ledr), 32'd1);
        for (int k = 2; k <= 10; k++) begin
            wait_change(600, el);
            check("t2_light_pattern", 32'(ledr), 32'((1 << k) - 1));
        end
        wait_change(100, el);
        check("t2_hold_rnd0_ms", 32'(el), 32'd50);
        run_ms(250);
        check("t2_react_ms_count", 32'(react_ms), 32'd250);
        exp_q.push_back({2'b00, 14'd250});
        do_ms(1'b1);
        react = 1'b0;
        @(negedge clk);
        check("t2_coincident_react_ms", 32'(react_ms), 32'd250);
        check("t2_done_busy", 32'(busy), 32'd0);

        // Jump start after 4 lights
        press_trigger();
        lights_up(4, "t3");
        exp_q.push_back({1'b1, 5'd0, 10'h3FF});
        press_react();
        check("t3_jump_start", 32'(jump_start), 32'd1);
        check("t3_jump_ledr", 32'(ledr), 32'h3FF);
        check("t3_jump_react_ms", 32'(react_ms), 32'd0);
        check("t3_jump_busy", 32'(busy), 32'd0);
        check("t3_jump_en_lfsr", 32'(en_lfsr), 32'd0);
        press_react();
        run_ms(600);
        check("t3_hold_jump", 32'(jump_start), 32'd1);
        check("t3_hold_ledr", 32'(ledr), 32'h3FF);
        check("t3_hold_busy", 32'(busy), 32'd0);
        press_trigger();
        check("t3_restart_jump", 32'(jump_start), 32'd0);
        check("t3_restart_ledr", 32'(ledr), 32'd0);
        check("t3_restart_busy", 32'(busy), 32'd1);

        // No reaction: times out at 9999 ms
        lights_up(10, "t4");
        wait_change(100, el);
        check("t4_hold_rnd0_ms", 32'(el), 32'd50);
        exp_q.push_back({2'b00, 14'd9999});
        el = 0;
        while (busy && el < 10100) begin
            do_ms(1'b0);
            el++;
        end
        check("t4_timeout_ms", 32'(el), 32'd9999);
        check("t4_timeout_react_ms", 32'(react_ms), 32'd9999);
        check("t4_timeout_busy", 32'(busy), 32'd0);
        run_ms(5);
        check("t4_timeout_hold", 32'(react_ms), 32'd9999);

        // Reset during RAND_WAIT
        rnd = 6'd20;
        press_trigger();
        lights_up(10, "t5");
        run_ms(100);
        check("t5_rand_wait_busy", 32'(busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ledr", 32'(ledr), 32'd0);
        check("t5_rst_en_lfsr", 32'(en_lfsr), 32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_react_ms", 32'(react_ms), 32'd0);
        trigger = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run_ms(3);
        check("t5_held_trigger_no_edge", 32'(busy), 32'd0);
        press_react();
        check("t5_react_ignored_jump", 32'(jump_start), 32'd0);
        check("t5_react_ignored_en_lfsr", 32'(en_lfsr), 32'd1);
        trigger = 1'b0;
        run_ms(1);
        press_trigger();
        check("t5_restart_busy", 32'(busy), 32'd1);

        run_ms(2);
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
